// File: rtl/dff_pipe.sv
// dff_pipe: elastic valid/ready register pipeline with bubble collapsing and synchronous flush.
// Optional occupancy output Count is built when DFF_PIPE_COUNT_EN is defined.
`default_nettype none

module dff_pipe #(
   parameter int Width = 4,
   parameter int Depth = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Width-1:0] Data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] Q
`ifdef DFF_PIPE_COUNT_EN
   ,
   output logic [$clog2(Depth+1)-1:0] Count
`endif
);

   logic [Depth-1:0] v;
   logic [Depth-1:0] adv;
   logic [Width-1:0] d [Depth];

   // A stage may advance when any stage from it to the output is empty, or the output drains.
   always_comb begin
      logic run;
      run = 1'b1;
      adv = '0;
      for (int i = 0; i < Depth; i++) begin
         run = 1'b1;
         for (int j = i; j < Depth; j++) begin
            run = run & v[j];
         end
         adv[i] = ~run | out_ready;
      end
   end

   assign in_ready  = adv[0] & ~Flush;
   assign out_valid = v[Depth-1];
   assign Q         = d[Depth-1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v <= '0;
         for (int i = 0; i < Depth; i++) begin
            d[i] <= '0;
         end
      end else begin
         if (adv[0]) begin
            v[0] <= in_valid & in_ready;
            d[0] <= Data;
         end
         for (int i = 1; i < Depth; i++) begin
            if (adv[i]) begin
               v[i] <= v[i-1];
               d[i] <= d[i-1];
            end
         end
         // Flush drops every word; data registers simply keep whatever they latched.
         if (Flush) begin
            v <= '0;
         end
      end
   end

`ifdef DFF_PIPE_COUNT_EN
   localparam int CW = $clog2(Depth+1);

   logic [CW-1:0] cnt;
   logic          xfer_in;
   logic          xfer_out;

   assign xfer_in  = in_valid & in_ready;
   assign xfer_out = out_valid & out_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (Flush) begin
         cnt <= '0;
      end else if (xfer_in && !xfer_out) begin
         cnt <= cnt + CW'(1);
      end else if (!xfer_in && xfer_out) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign Count = cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (Width=4, Depth=3).
`default_nettype none

module tb_dff_pipe;

   localparam int Width = 4;
   localparam int Depth = 3;

   logic             CLK = 1'b0;
   logic             RST;
   logic             Flush;
   logic             in_valid;
   logic             in_ready;
   logic [Width-1:0] Data;
   logic             out_valid;
   logic             out_ready;
   logic [Width-1:0] Q;
`ifdef DFF_PIPE_COUNT_EN
   logic [$clog2(Depth+1)-1:0] Count;
`endif

   dff_pipe #(.Width(Width), .Depth(Depth)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Flush     (Flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Data      (Data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Q         (Q)
`ifdef DFF_PIPE_COUNT_EN
      ,
      .Count     (Count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int npop   = 0;
   logic [Width-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then return just after the rising edge.
   task automatic tick();
      logic             fl;
      logic [Width-1:0] exp;
      @(negedge CLK);
      fl = Flush;
      if (out_valid && out_ready) begin
         check("out_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("q_order", {28'd0, Q}, {28'd0, exp});
         end
         npop++;
      end
      if (in_valid && in_ready) sb.push_back(Data);
      @(posedge CLK);
      #1;
      if (fl) sb.delete();
   endtask

   int lat;
   int base;

   initial begin
      RST = 1'b1; Flush = 1'b0; in_valid = 1'b0; Data = '0; out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_q", {28'd0, Q}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Latency of a single word
      out_ready = 1'b1; in_valid = 1'b1; Data = 4'hA;
      tick();
      in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check("latency", lat, 3);
      check("latency_q", {28'd0, Q}, 32'hA);
      tick();

      // Back-to-back streaming
      base = npop;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1'b1; Data = 4'(k);
         check("stream_in_ready", {31'd0, in_ready}, 32'd1);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("stream_pops_partial", npop - base, 7);
      tick();
      check("stream_pops", npop - base, 8);

      // Stall and fill
      out_ready = 1'b0;
      in_valid = 1'b1; Data = 4'h3; check("fill_rdy0", {31'd0, in_ready}, 32'd1); tick();
      Data = 4'h5;                   check("fill_rdy1", {31'd0, in_ready}, 32'd1); tick();
      Data = 4'h7;                   check("fill_rdy2", {31'd0, in_ready}, 32'd1); tick();
      Data = 4'h9;                   check("full_rdy", {31'd0, in_ready}, 32'd0); tick();
      in_valid = 1'b0;
      check("full_q", {28'd0, Q}, 32'h3);
`ifdef DFF_PIPE_COUNT_EN
      check("full_count", {30'd0, Count}, 32'd3);
`endif
      out_ready = 1'b1;
      #1 check("full_rdy_out_ready", {31'd0, in_ready}, 32'd1);
      tick(); tick(); tick();
      check("drained_out_valid", {31'd0, out_valid}, 32'd0);

      // Bubble collapse under stall
      out_ready = 1'b0;
      in_valid = 1'b1; Data = 4'hC; tick();
      in_valid = 1'b0; tick(); tick();
      in_valid = 1'b1; Data = 4'hD; tick();
      in_valid = 1'b0; tick();
      check("bubble_out_valid", {31'd0, out_valid}, 32'd1);
      check("bubble_q", {28'd0, Q}, 32'hC);
      check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_COUNT_EN
      check("bubble_count", {30'd0, Count}, 32'd2);
`endif
      out_ready = 1'b1;
      tick();
      check("bubble_next_valid", {31'd0, out_valid}, 32'd1);
      check("bubble_next_q", {28'd0, Q}, 32'hD);
      tick();

      // Flush colliding with input on a full pipeline
      out_ready = 1'b0;
      in_valid = 1'b1;
      Data = 4'h1; tick();
      Data = 4'h2; tick();
      Data = 4'h4; tick();
      Flush = 1'b1; Data = 4'hF;
      #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      Flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef DFF_PIPE_COUNT_EN
      check("flush_count", {30'd0, Count}, 32'd0);
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_flush_idle", {31'd0, out_valid}, 32'd0);
      end

      // Asynchronous reset with words in flight
      out_ready = 1'b0;
      in_valid = 1'b1; Data = 4'h6; tick();
      Data = 4'hB; tick();
      in_valid = 1'b0; tick();
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 RST = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_q", {28'd0, Q}, 32'd0);
      sb.delete();
      #1 RST = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_idle", {31'd0, out_valid}, 32'd0);
      end

      // Traffic resumes after reset
      in_valid = 1'b1; Data = 4'h2;
      check("resume_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
